// File: rtl/frame_buffer_writer.sv
// Raster-order pixel stream to rotated, column-major SRAM writer for the VGA frame memory.
// Each accepted pixel (x,y) lands at BASE + x*H + y one cycle after it is accepted.
module frame_buffer_writer #(
  parameter int D_WIDTH  = 320,
  parameter int D_HEIGHT = 320,
  parameter int D_BASE   = 204800,
  parameter int E_WIDTH  = 640,
  parameter int E_HEIGHT = 320,
  parameter int E_BASE   = 0,
  parameter int ADDR_W   = 19,
  parameter int DATA_W   = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic              selected_i,
  input  logic              pix_valid_i,
  input  logic [DATA_W-1:0] pix_data_i,
  output logic              pix_ready_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_address_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  output logic              busy_o,
  output logic              done_o,
  output logic [1:0]        state_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    DONE  = 2'd2
  } state_e;

  localparam logic [ADDR_W-1:0] ONE    = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] D_XMAX = ADDR_W'(D_WIDTH - 1);
  localparam logic [ADDR_W-1:0] D_YMAX = ADDR_W'(D_HEIGHT - 1);
  localparam logic [ADDR_W-1:0] D_STEP = ADDR_W'(D_HEIGHT);
  localparam logic [ADDR_W-1:0] D_BAS  = ADDR_W'(D_BASE);
  localparam logic [ADDR_W-1:0] E_XMAX = ADDR_W'(E_WIDTH - 1);
  localparam logic [ADDR_W-1:0] E_YMAX = ADDR_W'(E_HEIGHT - 1);
  localparam logic [ADDR_W-1:0] E_STEP = ADDR_W'(E_HEIGHT);
  localparam logic [ADDR_W-1:0] E_BAS  = ADDR_W'(E_BASE);

  state_e              state_q, state_d;
  logic                sel_q, sel_d;
  logic [ADDR_W-1:0]   x_q, x_d;
  logic [ADDR_W-1:0]   y_q, y_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;   // address of the next pixel to accept
  logic [ADDR_W-1:0]   row_q, row_d;     // BASE + y: address of column 0 in the current row
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   maddr_q, maddr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;

  logic                accept;
  logic [ADDR_W-1:0]   x_max, y_max, step;

  // Handshake: a pixel transfers on a rising edge where pix_valid_i and pix_ready_o
  // are both high; pix_ready_o depends only on state, never on pix_valid_i.
  assign pix_ready_o = (state_q == WRITE);
  assign accept      = pix_ready_o && pix_valid_i;
  assign busy_o      = (state_q != IDLE);
  assign done_o      = (state_q == DONE);
  assign state_o     = state_q;

  assign mem_we_o      = we_q;
  assign mem_address_o = maddr_q;
  assign mem_wdata_o   = wdata_q;

  assign x_max = sel_q ? E_XMAX : D_XMAX;
  assign y_max = sel_q ? E_YMAX : D_YMAX;
  assign step  = sel_q ? E_STEP : D_STEP;

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    x_d     = x_q;
    y_d     = y_q;
    addr_d  = addr_q;
    row_d   = row_q;
    we_d    = 1'b0;
    maddr_d = maddr_q;
    wdata_d = wdata_q;

    case (state_q)
      IDLE: begin
        if (start_i) begin
          sel_d   = selected_i;
          x_d     = '0;
          y_d     = '0;
          addr_d  = selected_i ? E_BAS : D_BAS;
          row_d   = selected_i ? E_BAS : D_BAS;
          state_d = WRITE;
        end
      end
      WRITE: begin
        if (accept) begin
          we_d    = 1'b1;
          maddr_d = addr_q;
          wdata_d = pix_data_i;
          if (x_q == x_max) begin
            // Row wrap: the next column-0 address is one past this row's start.
            x_d    = '0;
            y_d    = y_q + ONE;
            row_d  = row_q + ONE;
            addr_d = row_q + ONE;
            if (y_q == y_max) begin
              state_d = DONE;
            end
          end else begin
            x_d    = x_q + ONE;
            addr_d = addr_q + step;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      sel_q   <= 1'b0;
      x_q     <= '0;
      y_q     <= '0;
      addr_q  <= '0;
      row_q   <= '0;
      we_q    <= 1'b0;
      maddr_q <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      x_q     <= x_d;
      y_q     <= y_d;
      addr_q  <= addr_d;
      row_q   <= row_d;
      we_q    <= we_d;
      maddr_q <= maddr_d;
      wdata_q <= wdata_d;
    end
  end

endmodule

// File: tb/tb_frame_buffer_writer.sv
// Directed bench for frame_buffer_writer: a full-size instance for address checkpoints and
// mid-frame reset, and a reduced-size instance for complete frames, done timing and backpressure.
module tb_frame_buffer_writer;

  logic        clk;
  logic        rst;
  logic        start;
  logic        selected;
  logic        pix_valid;
  logic [7:0]  pix_data;

  logic        f_ready, f_we, f_busy, f_done;
  logic [18:0] f_addr;
  logic [7:0]  f_data;
  logic [1:0]  f_state;

  logic        s_ready, s_we, s_busy, s_done;
  logic [18:0] s_addr;
  logic [7:0]  s_data;
  logic [1:0]  s_state;

  bit          use_full;
  logic        o_ready, o_we, o_busy, o_done;
  logic [18:0] o_addr;
  logic [7:0]  o_data;
  logic [1:0]  o_state;

  int n_vec;
  int n_err;
  int addr_log [0:1023];
  int last_addr;
  int nw;
  int nd;

  frame_buffer_writer u_full (
    .clk_i         (clk),
    .rst_i         (rst),
    .start_i       (start),
    .selected_i    (selected),
    .pix_valid_i   (pix_valid),
    .pix_data_i    (pix_data),
    .pix_ready_o   (f_ready),
    .mem_we_o      (f_we),
    .mem_address_o (f_addr),
    .mem_wdata_o   (f_data),
    .busy_o        (f_busy),
    .done_o        (f_done),
    .state_o       (f_state)
  );

  frame_buffer_writer #(
    .D_WIDTH  (8),
    .D_HEIGHT (4),
    .D_BASE   (204800),
    .E_WIDTH  (16),
    .E_HEIGHT (4),
    .E_BASE   (0)
  ) u_small (
    .clk_i         (clk),
    .rst_i         (rst),
    .start_i       (start),
    .selected_i    (selected),
    .pix_valid_i   (pix_valid),
    .pix_data_i    (pix_data),
    .pix_ready_o   (s_ready),
    .mem_we_o      (s_we),
    .mem_address_o (s_addr),
    .mem_wdata_o   (s_data),
    .busy_o        (s_busy),
    .done_o        (s_done),
    .state_o       (s_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    if (use_full) begin
      o_ready = f_ready; o_we = f_we; o_busy = f_busy; o_done = f_done;
      o_addr  = f_addr;  o_data = f_data; o_state = f_state;
    end else begin
      o_ready = s_ready; o_we = s_we; o_busy = s_busy; o_done = s_done;
      o_addr  = s_addr;  o_data = s_data; o_state = s_state;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic reset_pulse();
    @(negedge clk);
    rst = 1'b1; start = 1'b0; pix_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Runs one frame on the observed instance until max_wr writes are seen, checking every
  // write against base + x*h + y and the one-cycle accept-to-write latency.
  task automatic run_frame(input bit full, input bit sel, input int w, input int h,
                           input int base, input int max_wr, input bit gaps, input bit poke,
                           output int n_wr, output int n_done);
    int  acc;
    int  budget;
    int  iter;
    bit  prev_acc;
    use_full = full;
    acc = 0; n_wr = 0; n_done = 0; prev_acc = 1'b0; iter = 0;
    budget = 4 * max_wr + 64;
    @(negedge clk);
    start = 1'b1; selected = sel; pix_valid = 1'b0;
    while (n_wr < max_wr && budget > 0) begin
      @(negedge clk);
      budget--;
      iter++;
      start = 1'b0;
      check("we_after_accept", {31'd0, o_we}, {31'd0, prev_acc});
      check("busy_in_frame", {31'd0, o_busy}, 32'd1);
      if (o_we) begin
        check("addr", {13'd0, o_addr}, base + (n_wr % w) * h + n_wr / w);
        check("data", {24'd0, o_data}, n_wr % 256);
        if (n_wr < 1024) addr_log[n_wr] = int'(o_addr);
        last_addr = int'(o_addr);
        n_wr++;
      end
      if (o_done) begin
        n_done++;
        check("done_at_last_write", n_wr, w * h);
      end
      if (poke && iter == 20) begin
        start = 1'b1;
        selected = ~sel;
      end
      pix_valid = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
      pix_data  = 8'(acc);
      prev_acc  = pix_valid && o_ready;
      if (prev_acc) acc++;
    end
    if (n_wr < max_wr) check("frame_timeout", n_wr, max_wr);
  endtask

  task automatic check_idle_after(input string tag);
    @(negedge clk);
    check({tag, "_done"},  {31'd0, o_done},  32'd0);
    check({tag, "_busy"},  {31'd0, o_busy},  32'd0);
    check({tag, "_we"},    {31'd0, o_we},    32'd0);
    check({tag, "_ready"}, {31'd0, o_ready}, 32'd0);
  endtask

  initial begin
    n_vec = 0; n_err = 0; use_full = 1'b1;
    rst = 1'b1; start = 1'b0; selected = 1'b0; pix_valid = 1'b1; pix_data = 8'hA5;

    // Reset with pix_valid high: everything quiet
    repeat (3) @(negedge clk);
    check("rst_ready", {31'd0, f_ready}, 32'd0);
    check("rst_we",    {31'd0, f_we},    32'd0);
    check("rst_addr",  {13'd0, f_addr},  32'd0);
    check("rst_wdata", {24'd0, f_data},  32'd0);
    check("rst_busy",  {31'd0, f_busy},  32'd0);
    check("rst_done",  {31'd0, f_done},  32'd0);
    check("rst_state", {30'd0, f_state}, 32'd0);
    check("rst_small_state", {30'd0, s_state}, 32'd0);
    rst = 1'b0;
    repeat (4) begin
      @(negedge clk);
      check("idle_ready", {31'd0, f_ready}, 32'd0);
      check("idle_we",    {31'd0, f_we},    32'd0);
    end

    // Full-size decrypted region: first 700 writes
    reset_pulse();
    run_frame(1'b1, 1'b0, 320, 320, 204800, 700, 1'b0, 1'b0, nw, nd);
    check("d_px0",   addr_log[0],   204800);
    check("d_px1",   addr_log[1],   205120);
    check("d_px319", addr_log[319], 306880);
    check("d_px320", addr_log[320], 204801);
    check("d_state_write", {30'd0, o_state}, 32'd1);

    // Full-size encrypted region: first 700 writes
    reset_pulse();
    run_frame(1'b1, 1'b1, 640, 320, 0, 700, 1'b0, 1'b0, nw, nd);
    check("e_px0",   addr_log[0],   0);
    check("e_px1",   addr_log[1],   320);
    check("e_px639", addr_log[639], 204480);
    check("e_px640", addr_log[640], 1);

    // Reduced decrypted frame, complete
    reset_pulse();
    run_frame(1'b0, 1'b0, 8, 4, 204800, 32, 1'b0, 1'b0, nw, nd);
    check("sd_writes", nw, 32);
    check("sd_dones",  nd, 1);
    check("sd_px1",    addr_log[1], 204804);
    check("sd_px7",    addr_log[7], 204828);
    check("sd_px8",    addr_log[8], 204801);
    check("sd_last",   last_addr,   204831);
    check_idle_after("sd_post");

    // Reduced encrypted frame, complete
    reset_pulse();
    run_frame(1'b0, 1'b1, 16, 4, 0, 64, 1'b0, 1'b0, nw, nd);
    check("se_writes", nw, 64);
    check("se_dones",  nd, 1);
    check("se_px1",    addr_log[1],  4);
    check("se_px15",   addr_log[15], 60);
    check("se_px16",   addr_log[16], 1);
    check("se_last",   last_addr,    63);
    check_idle_after("se_post");

    // Backpressure: random pix_valid gaps, same address sequence
    reset_pulse();
    run_frame(1'b0, 1'b0, 8, 4, 204800, 32, 1'b1, 1'b0, nw, nd);
    check("bp_writes", nw, 32);
    check("bp_dones",  nd, 1);
    check("bp_last",   last_addr, 204831);
    check_idle_after("bp_post");

    // start pulse and selected toggle mid-frame are ignored
    reset_pulse();
    run_frame(1'b0, 1'b1, 16, 4, 0, 64, 1'b1, 1'b1, nw, nd);
    check("poke_writes", nw, 64);
    check("poke_dones",  nd, 1);
    check("poke_last",   last_addr, 63);
    check_idle_after("poke_post");

    // Reset after 1000 writes, then a fresh decrypted start
    reset_pulse();
    run_frame(1'b1, 1'b0, 320, 320, 204800, 1000, 1'b0, 1'b0, nw, nd);
    rst = 1'b1;
    @(negedge clk);
    check("mr_we",    {31'd0, f_we},    32'd0);
    check("mr_busy",  {31'd0, f_busy},  32'd0);
    check("mr_ready", {31'd0, f_ready}, 32'd0);
    rst = 1'b0;
    run_frame(1'b1, 1'b0, 320, 320, 204800, 2, 1'b0, 1'b0, nw, nd);
    check("mr_px0", addr_log[0], 204800);
    check("mr_px1", addr_log[1], 205120);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/frame_buffer_writer.md
Name: frame_buffer_writer

Overview:
- Writer side of the VGA frame memory: accepts a raster-order pixel stream (row by row, left to right) from the decrypt/encrypt datapath.
- Writes each pixel into the shared 8-bit pixel SRAM at the rotated, column-major address that the VGA display path reads back.
- Two regions, selected per frame: decrypted image (320x320 at base 204800) and encrypted image (640x320 at base 0).
- Sits between the processor pixel output and the SRAM write port.

Parameters:
- D_WIDTH, 320, decrypted image width in pixels
- D_HEIGHT, 320, decrypted image height in pixels
- D_BASE, 204800, SRAM base address of decrypted region
- E_WIDTH, 640, encrypted image width in pixels
- E_HEIGHT, 320, encrypted image height in pixels
- E_BASE, 0, SRAM base address of encrypted region
- ADDR_W, 19, SRAM address width
- DATA_W, 8, pixel width

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- start  in  1  one-cycle request to begin a frame; sampled only in IDLE
- selected  in  1  region select, latched on accepted start: 0 = decrypted, 1 = encrypted
- pix_valid  in  1  pix_data holds a valid pixel
- pix_data  in  DATA_W  pixel value
- pix_ready  out  1  writer can accept a pixel this cycle
- mem_we  out  1  SRAM write enable
- mem_address  out  ADDR_W  SRAM write address
- mem_wdata  out  DATA_W  SRAM write data
- busy  out  1  frame in progress
- done  out  1  one-cycle pulse after the final pixel is written

Behaviour:
- Reset (async, rst=1): state IDLE; x=0, y=0; all outputs 0 (pix_ready, mem_we, mem_address, mem_wdata, busy, done).
- States: IDLE, WRITE, DONE.
- IDLE:
  - pix_ready=0, busy=0.
  - start=1: latch selected into sel_q; set x=0, y=0; next state WRITE.
  - start is ignored in every other state.
- WRITE:
  - busy=1; pix_ready=1, driven combinationally from state.
  - A pixel is accepted when pix_valid & pix_ready. pix_valid low: no acceptance, counters hold, no write.
  - W = sel_q ? E_WIDTH : D_WIDTH; H = sel_q ? E_HEIGHT : D_HEIGHT; BASE = sel_q ? E_BASE : D_BASE.
  - For the pixel at (x,y): address = BASE + x*H + y.
  - Counter update after acceptance: x increments; when x = W-1, x wraps to 0 and y increments.
  - Address arithmetic runs at ADDR_W bits. Incremental update (add H per pixel, reset to BASE+y+1 on row wrap) is permitted; no multiplier is required.
  - Last pixel is x = W-1, y = H-1. Its acceptance moves the state to DONE.
- Write timing:
  - 1-cycle registered latency: an acceptance in cycle N gives mem_we=1, mem_address and mem_wdata for that pixel in cycle N+1.
  - No acceptance in cycle N gives mem_we=0 in cycle N+1; mem_address and mem_wdata hold their previous values.
- DONE:
  - Lasts one cycle. pix_ready=0, busy=1, done=1.
  - The last pixel's write (mem_we=1) occurs in this same cycle.
  - Next state IDLE; done returns to 0.
- selected changes after start are ignored until the next accepted start.
- rst asserted mid-frame: immediate return to IDLE; no further writes; any pending write is dropped (mem_we=0).
- Throughput: 1 pixel/clk when pix_valid is held high.
  - Decrypted frame: 102400 accepts.
  - Encrypted frame: 204800 accepts.
  - done occurs one cycle after the final accept.

Test Plan:
- Reset/idle: assert rst with pix_valid=1 and start=0 -> all outputs 0; pix_ready stays 0 with no start.
- Decrypted frame, selected=0, pix_valid held 1, pix_data = index mod 256:
  - pixel 0 -> addr 204800; pixel 1 -> 205120; pixel 319 -> 306880; pixel 320 -> 204801; last pixel -> 307199.
  - done pulses once, in the cycle of the last write; exactly 102400 writes.
- Encrypted frame, selected=1:
  - pixel 0 -> addr 0; pixel 1 -> 320; pixel 639 -> 204480; pixel 640 -> 1; last pixel -> 204799.
  - 204800 writes; no address reaches 204800.
- Backpressure: random pix_valid gaps -> mem_we asserted only in the cycle after each accept; address sequence identical to the gap-free run.
- Start/selected during busy: pulse start and toggle selected mid-frame -> no restart; region unchanged; busy stays 1 until done.
- Reset mid-frame: rst after 1000 accepts -> next cycle mem_we=0, busy=0. A new start with selected=0 writes its first pixel to 204800.
